ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- single-issue RV32I instruction decoder with a registered control bundle.
//
// Each accepted 32-bit instruction is decoded into a control bundle. The bundle
// appears one cycle after the accept, qualified by ctrl_valid_o. A mul/div
// instruction holds the decoder for MD_CYCLES cycles. Its bundle is emitted when
// that countdown ends. Mul/div decode exists only when the macro
// CTRL_PIPE_MD_EN is defined. Without it, funct7 0000001 decodes as illegal and
// the md outputs are tied to 0.
//
// Parameters
//   XLEN       datapath width, documentation only (the instruction is always 32 bits)
//   MD_CYCLES  total cycles a mul/div instruction occupies the decoder (>= 2)
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   instr_i, instr_valid_i        instruction word and its valid
//   instr_ready_o                 decoder accepts instr_i this cycle
//   stall_i                       execute stage cannot take a bundle; holds everything
//   flush_i                       kills the held bundle and any in-flight mul/div
//   ctrl_valid_o                  bundle below is valid
//   alu_op_o, reg_wr_o, sel_a_o (1 = PC), sel_b_o (1 = immediate), wb_sel_o, br_type_o
//   cs_o (active-low chip select), rd_wr_o (1 = load), mask_o
//   csr_op_o, mret_o, illegal_o, md_op_o, md_o, md_busy_o
module ctrl_pipe #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        ctrl_valid_o,
    output logic [3:0]  alu_op_o,
    output logic        reg_wr_o,
    output logic        sel_a_o,
    output logic        sel_b_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  br_type_o,
    output logic        cs_o,
    output logic        rd_wr_o,
    output logic [2:0]  mask_o,
    output logic [1:0]  csr_op_o,
    output logic        mret_o,
    output logic        illegal_o,
    output logic [2:0]  md_op_o,
    output logic        md_o,
    output logic        md_busy_o
);

`ifdef CTRL_PIPE_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam int CW = $clog2(MD_CYCLES + 1);

    if (MD_CYCLES < 2 || XLEN < 32) begin : g_bad_cfg
        $error("ctrl_pipe: MD_CYCLES must be >= 2 and XLEN >= 32");
    end

    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_wr;
        logic       sel_a;
        logic       sel_b;
        logic [1:0] wb_sel;
        logic [2:0] br_type;
        logic       cs;
        logic       rd_wr;
        logic [2:0] mask;
        logic [1:0] csr_op;
        logic       mret;
        logic       illegal;
        logic [2:0] md_op;
        logic       md;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{alu_op: 4'd0, reg_wr: 1'b0, sel_a: 1'b0, sel_b: 1'b0,
                                 wb_sel: 2'd0, br_type: 3'd0, cs: 1'b1, rd_wr: 1'b1,
                                 mask: 3'd0, csr_op: 2'd0, mret: 1'b0, illegal: 1'b0,
                                 md_op: 3'd0, md: 1'b0};

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLT = 4'b0010,
                           ALU_SLTU = 4'b0011, ALU_AND = 4'b0100, ALU_OR = 4'b0101,
                           ALU_XOR = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                           ALU_SRA = 4'b1001, ALU_LUI = 4'b1010;

    typedef enum logic [0:0] {IDLE, MD_BUSY} state_t;

    state_t        r_state, w_nxt_state;
    logic [CW-1:0] r_cnt, w_nxt_cnt;
    logic          r_valid, w_nxt_valid;
    ctrl_t         r_bundle, w_nxt_bundle;
    logic [2:0]    r_md_op, w_nxt_md_op;

    logic [6:0] w_op, w_f7;
    logic [2:0] w_f3;
    ctrl_t      w_dec;
    logic       w_dec_md;
    logic       w_ill;
    logic       w_accept;

    assign w_op = instr_i[6:0];
    assign w_f3 = instr_i[14:12];
    assign w_f7 = instr_i[31:25];

    assign instr_ready_o = (r_state == IDLE) & ~stall_i & ~flush_i;
    assign w_accept      = instr_valid_i & instr_ready_o;

    // Combinational decode. Any undefined encoding collapses to a bubble with
    // only illegal set.
    always_comb begin
        w_dec    = BUBBLE;
        w_dec_md = 1'b0;
        w_ill    = 1'b0;
        case (w_op)
            OP_R: begin
                w_dec.reg_wr = 1'b1;
                w_dec.wb_sel = 2'b01;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_dec.alu_op = ALU_ADD;
                        3'b001:  w_dec.alu_op = ALU_SLL;
                        3'b010:  w_dec.alu_op = ALU_SLT;
                        3'b011:  w_dec.alu_op = ALU_SLTU;
                        3'b100:  w_dec.alu_op = ALU_XOR;
                        3'b101:  w_dec.alu_op = ALU_SRL;
                        3'b110:  w_dec.alu_op = ALU_OR;
                        default: w_dec.alu_op = ALU_AND;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    case (w_f3)
                        3'b000:  w_dec.alu_op = ALU_SUB;
                        3'b101:  w_dec.alu_op = ALU_SRA;
                        default: w_ill = 1'b1;
                    endcase
                end else if (w_f7 == 7'b0000001 && MD_EN) begin
                    w_dec_md = 1'b1;
                end else begin
                    w_ill = 1'b1;
                end
            end
            OP_I: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_b  = 1'b1;
                w_dec.wb_sel = 2'b01;
                case (w_f3)
                    3'b000: w_dec.alu_op = ALU_ADD;
                    3'b010: w_dec.alu_op = ALU_SLT;
                    3'b011: w_dec.alu_op = ALU_SLTU;
                    3'b100: w_dec.alu_op = ALU_XOR;
                    3'b110: w_dec.alu_op = ALU_OR;
                    3'b111: w_dec.alu_op = ALU_AND;
                    3'b001: begin
                        if (w_f7 == 7'b0000000) w_dec.alu_op = ALU_SLL;
                        else                    w_ill = 1'b1;
                    end
                    default: begin
                        if (w_f7 == 7'b0000000)      w_dec.alu_op = ALU_SRL;
                        else if (w_f7 == 7'b0100000) w_dec.alu_op = ALU_SRA;
                        else                         w_ill = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_b  = 1'b1;
                w_dec.cs     = 1'b0;
                w_dec.rd_wr  = 1'b1;
                case (w_f3)
                    3'b000:  w_dec.mask = 3'b010;
                    3'b001:  w_dec.mask = 3'b001;
                    3'b010:  w_dec.mask = 3'b000;
                    3'b100:  w_dec.mask = 3'b100;
                    3'b101:  w_dec.mask = 3'b011;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                w_dec.sel_b = 1'b1;
                w_dec.cs    = 1'b0;
                w_dec.rd_wr = 1'b0;
                case (w_f3)
                    3'b000:  w_dec.mask = 3'b010;
                    3'b001:  w_dec.mask = 3'b001;
                    3'b010:  w_dec.mask = 3'b000;
                    default: w_ill = 1'b1;   // 011 (sd) has no RV32 meaning
                endcase
            end
            OP_BR: begin
                w_dec.alu_op = ALU_SUB;      // compare operands by subtraction
                case (w_f3)
                    3'b000:  w_dec.br_type = 3'b010;
                    3'b001:  w_dec.br_type = 3'b001;
                    3'b010,
                    3'b011:  w_ill = 1'b1;
                    default: w_dec.br_type = w_f3;  // blt/bge/bltu/bgeu codes equal funct3
                endcase
            end
            OP_LUI: begin
                w_dec.alu_op = ALU_LUI;
                w_dec.reg_wr = 1'b1;
                w_dec.sel_b  = 1'b1;
                w_dec.wb_sel = 2'b01;
            end
            OP_AUIPC: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_a  = 1'b1;
                w_dec.sel_b  = 1'b1;
                w_dec.wb_sel = 2'b01;
            end
            OP_JAL: begin
                w_dec.reg_wr  = 1'b1;
                w_dec.sel_a   = 1'b1;
                w_dec.sel_b   = 1'b1;
                w_dec.wb_sel  = 2'b10;
                w_dec.br_type = 3'b011;
            end
            OP_JALR: begin
                if (w_f3 == 3'b000) begin
                    w_dec.reg_wr  = 1'b1;
                    w_dec.sel_b   = 1'b1;
                    w_dec.wb_sel  = 2'b10;
                    w_dec.br_type = 3'b011;
                end else begin
                    w_ill = 1'b1;
                end
            end
            OP_SYS: begin
                if (instr_i == 32'h3020_0073) begin
                    w_dec.mret = 1'b1;
                end else if (w_f3 == 3'b001 || w_f3 == 3'b010 || w_f3 == 3'b011) begin
                    w_dec.csr_op = w_f3[1:0];
                    w_dec.reg_wr = 1'b1;
                    w_dec.wb_sel = 2'b11;
                end else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_dec         = BUBBLE;
            w_dec.illegal = 1'b1;
        end
    end

    // Next state / bundle. Priority: flush, then stall, then normal flow.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_valid  = r_valid;
        w_nxt_bundle = r_bundle;
        w_nxt_md_op  = r_md_op;
        if (flush_i) begin
            w_nxt_state  = IDLE;
            w_nxt_cnt    = '0;
            w_nxt_valid  = 1'b0;
            w_nxt_bundle = BUBBLE;
        end else if (!stall_i) begin
            w_nxt_valid  = 1'b0;
            w_nxt_bundle = BUBBLE;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_dec_md) begin
                            w_nxt_state = MD_BUSY;
                            w_nxt_cnt   = CW'(MD_CYCLES - 1);
                            w_nxt_md_op = w_f3;
                        end else begin
                            w_nxt_valid  = 1'b1;
                            w_nxt_bundle = w_dec;
                        end
                    end
                end
                default: begin
                    if (r_cnt == CW'(1)) begin
                        w_nxt_state         = IDLE;
                        w_nxt_cnt           = '0;
                        w_nxt_valid         = 1'b1;
                        w_nxt_bundle.md     = 1'b1;
                        w_nxt_bundle.md_op  = r_md_op;
                        w_nxt_bundle.reg_wr = 1'b1;
                        w_nxt_bundle.wb_sel = 2'b01;
                    end else begin
                        w_nxt_cnt = r_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_bundle <= BUBBLE;
            r_md_op  <= 3'd0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_valid  <= w_nxt_valid;
            r_bundle <= w_nxt_bundle;
            r_md_op  <= w_nxt_md_op;
        end
    end

    assign ctrl_valid_o = r_valid;
    assign alu_op_o     = r_bundle.alu_op;
    assign reg_wr_o     = r_bundle.reg_wr;
    assign sel_a_o      = r_bundle.sel_a;
    assign sel_b_o      = r_bundle.sel_b;
    assign wb_sel_o     = r_bundle.wb_sel;
    assign br_type_o    = r_bundle.br_type;
    assign cs_o         = r_bundle.cs;
    assign rd_wr_o      = r_bundle.rd_wr;
    assign mask_o       = r_bundle.mask;
    assign csr_op_o     = r_bundle.csr_op;
    assign mret_o       = r_bundle.mret;
    assign illegal_o    = r_bundle.illegal;
    assign md_o         = MD_EN ? r_bundle.md : 1'b0;
    assign md_op_o      = MD_EN ? r_bundle.md_op : 3'd0;
    assign md_busy_o    = MD_EN ? (r_state == MD_BUSY) : 1'b0;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe. The driver pushes {due cycle, expected bundle}
// on every accept, and a negedge monitor pops and compares each new bundle.
// Sequences of direct checks cover reset, bubble return, stall/flush and mul/div.
module tb_ctrl_pipe;
    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic        instr_ready_o, ctrl_valid_o, reg_wr_o, sel_a_o, sel_b_o, cs_o, rd_wr_o;
    logic        mret_o, illegal_o, md_o, md_busy_o;
    logic [3:0]  alu_op_o;
    logic [1:0]  wb_sel_o, csr_op_o;
    logic [2:0]  br_type_o, mask_o, md_op_o;

    ctrl_pipe #(.XLEN(32), .MD_CYCLES(MD)) dut (
        .clk(clk), .rst(rst), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o), .stall_i(stall_i), .flush_i(flush_i),
        .ctrl_valid_o(ctrl_valid_o), .alu_op_o(alu_op_o), .reg_wr_o(reg_wr_o),
        .sel_a_o(sel_a_o), .sel_b_o(sel_b_o), .wb_sel_o(wb_sel_o), .br_type_o(br_type_o),
        .cs_o(cs_o), .rd_wr_o(rd_wr_o), .mask_o(mask_o), .csr_op_o(csr_op_o),
        .mret_o(mret_o), .illegal_o(illegal_o), .md_op_o(md_op_o), .md_o(md_o),
        .md_busy_o(md_busy_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic stall_q = 1'b0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        stall_q <= stall_i;
    end

    typedef struct {
        int          due;
        logic [24:0] exp;
        string       tag;
    } sb_t;
    sb_t sbq[$];
    sb_t mon_e;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // {alu, reg_wr, sel_a, sel_b, wb, br, cs, rd_wr, mask, csr, mret, illegal, md_op, md}
    function automatic logic [24:0] mk(input logic [3:0] alu, input logic rw, sa, sb,
                                       input logic [1:0] wb, input logic [2:0] br,
                                       input logic cs, rdw, input logic [2:0] msk,
                                       input logic [1:0] csr, input logic mr, ill,
                                       input logic [2:0] mdop, input logic md);
        return {alu, rw, sa, sb, wb, br, cs, rdw, msk, csr, mr, ill, mdop, md};
    endfunction

    function automatic logic [24:0] obsv();
        return {alu_op_o, reg_wr_o, sel_a_o, sel_b_o, wb_sel_o, br_type_o, cs_o, rd_wr_o,
                mask_o, csr_op_o, mret_o, illegal_o, md_op_o, md_o};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (ctrl_valid_o && !stall_q) begin
                if (sbq.size() == 0) begin
                    chk("unexp_valid", 32'(ctrl_valid_o), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk({mon_e.tag, "_lat"}, cyc, mon_e.due);
                    chk(mon_e.tag, 32'(obsv()), 32'(mon_e.exp));
                end
            end else if (sbq.size() != 0 && sbq[0].due < cyc) begin
                chk({sbq[0].tag, "_miss"}, 32'(ctrl_valid_o), 32'd1);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic send(input string tag, input logic [31:0] ins, input logic [24:0] exp,
                        input int lat);
        int t = 0;
        while (!instr_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_rdy"}, 32'(instr_ready_o), 32'd1);
        instr_i       = ins;
        instr_valid_i = 1'b1;
        if (lat > 0) sbq.push_back('{cyc + lat, exp, tag});
        @(negedge clk);
        instr_valid_i = 1'b0;
    endtask

    logic [24:0] x_bub, x_ill, x_add, x_mul;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        x_bub = mk(4'd0, 0, 0, 0, 2'd0, 3'd0, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 0);
        x_ill = mk(4'd0, 0, 0, 0, 2'd0, 3'd0, 1, 1, 3'd0, 2'd0, 0, 1, 3'd0, 0);
        x_add = mk(4'd0, 1, 0, 0, 2'd1, 3'd0, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 0);
        x_mul = mk(4'd0, 1, 0, 0, 2'd1, 3'd0, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 1);

        repeat (3) @(negedge clk);
        chk("rst_bundle", 32'({ctrl_valid_o, obsv()}), 32'({1'b0, x_bub}));
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_busy", 32'(md_busy_o), 32'd0);
        rst = 1'b0;

        // back-to-back decode stream
        send("add",   32'h002081B3, x_add, 1);
        send("sw",    32'h0020A423, mk(4'd0, 0, 0, 1, 2'd0, 3'd0, 0, 0, 3'd0, 2'd0, 0, 0, 3'd0, 0), 1);
        send("lbu",   32'h0000C183, mk(4'd0, 1, 0, 1, 2'd0, 3'd0, 0, 1, 3'd4, 2'd0, 0, 0, 3'd0, 0), 1);
        send("sub",   32'h402081B3, mk(4'd1, 1, 0, 0, 2'd1, 3'd0, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 0), 1);
        send("sra",   32'h4020D1B3, mk(4'd9, 1, 0, 0, 2'd1, 3'd0, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 0), 1);
        send("addi",  32'h00508193, mk(4'd0, 1, 0, 1, 2'd1, 3'd0, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 0), 1);
        send("beq",   32'h00208463, mk(4'd1, 0, 0, 0, 2'd0, 3'd2, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 0), 1);
        send("bltu",  32'h0020E463, mk(4'd1, 0, 0, 0, 2'd0, 3'd6, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 0), 1);
        send("lui",   32'h123451B7, mk(4'd10, 1, 0, 1, 2'd1, 3'd0, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 0), 1);
        send("jal",   32'h010000EF, mk(4'd0, 1, 1, 1, 2'd2, 3'd3, 1, 1, 3'd0, 2'd0, 0, 0, 3'd0, 0), 1);
        send("csrrw", 32'h300110F3, mk(4'd0, 1, 0, 0, 2'd3, 3'd0, 1, 1, 3'd0, 2'd1, 0, 0, 3'd0, 0), 1);
        send("mret",  32'h30200073, mk(4'd0, 0, 0, 0, 2'd0, 3'd0, 1, 1, 3'd0, 2'd0, 1, 0, 3'd0, 0), 1);
        send("zero",  32'h00000000, x_ill, 1);
        send("br010", 32'h0020A463, x_ill, 1);
        send("f7bad", 32'h202081B3, x_ill, 1);
        @(negedge clk);
        chk("bubble", 32'({ctrl_valid_o, obsv()}), 32'({1'b0, x_bub}));

        // stall holds the bundle and blocks new accepts
        send("add_st", 32'h002081B3, x_add, 1);
        stall_i = 1'b1; instr_valid_i = 1'b1; instr_i = 32'h402081B3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold", 32'({ctrl_valid_o, obsv()}), 32'({1'b1, x_add}));
            chk("stall_rdy", 32'(instr_ready_o), 32'd0);
        end
        stall_i = 1'b0; instr_valid_i = 1'b0;
        @(negedge clk);
        chk("stall_rel", 32'({ctrl_valid_o, obsv()}), 32'({1'b0, x_bub}));

        // flush beats stall on a held bundle
        send("add_fl", 32'h002081B3, x_add, 1);
        stall_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        stall_i = 1'b0; flush_i = 1'b0;
        chk("flush_kill", 32'({ctrl_valid_o, obsv()}), 32'({1'b0, x_bub}));

`ifdef CTRL_PIPE_MD_EN
        send("mul", 32'h022081B3, x_mul, MD);
        for (int i = 0; i < MD - 1; i++) begin
            chk("mul_rdy_lo", 32'(instr_ready_o), 32'd0);
            chk("mul_busy", 32'(md_busy_o), 32'd1);
            @(negedge clk);
        end
        chk("mul_rdy_hi", 32'(instr_ready_o), 32'd1);

        send("mul_fl", 32'h022081B3, x_mul, 0);
        @(negedge clk);
        flush_i = 1'b1;
        chk("mulfl_rdy", 32'(instr_ready_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        chk("mulfl_after", 32'({instr_ready_o, md_busy_o, ctrl_valid_o}), 32'b100);
        repeat (MD + 1) @(negedge clk);

        send("mul_st", 32'h022091B3, mk(4'd0, 1, 0, 0, 2'd1, 3'd0, 1, 1, 3'd0, 2'd0, 0, 0, 3'd1, 1), MD + 2);
        stall_i = 1'b1;
        repeat (2) @(negedge clk);
        stall_i = 1'b0;
        repeat (MD + 1) @(negedge clk);

        send("mul_rst", 32'h022081B3, x_mul, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mulrst", 32'({instr_ready_o, md_busy_o, ctrl_valid_o}), 32'b100);
        repeat (MD + 1) @(negedge clk);
`else
        send("mul_ill", 32'h022081B3, x_ill, 1);
        chk("mul_nobusy", 32'({instr_ready_o, md_busy_o}), 32'b10);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
